// File: rtl/cpu_pkg.sv
// Shared core definitions: default datapath sizes, writeback source
// encodings and elaboration-time helpers.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int REG_AW_DEF = 3;

  typedef enum logic [1:0] {
    WB_SRC_SHIFT = 2'd0,
    WB_SRC_ALU   = 2'd1,
    WB_SRC_MEM   = 2'd2,
    WB_SRC_IMM   = 2'd3
  } wb_src_e;

  // Bits needed to encode n distinct values (0 for n <= 1).
  function automatic int clog2(input int n);
    int bits;
    bits = 0;
    while ((1 << bits) < n) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/wb_src_mux.sv
// NUM_SRC:1 result selector for the writeback stage; a select value with
// no matching source yields zero.
module wb_src_mux #(
  parameter int DATA_W  = 8,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] src,
  output logic [DATA_W-1:0]         data
);

  always_comb begin
    // NOTE: default assignment first so every path drives data; no latch.
    data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(sel) == k) data = src[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage: one-entry pipeline register with valid/ready handshake,
// flush and stall, driving the register-file write port, EX bypass and a
// retired-instruction counter.
module wb_stage_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_SRC  = 4,
  parameter int SEL_W    = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_regwrite,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [NUM_SRC*DATA_W-1:0] in_src,
  input  logic                      flush,
  input  logic                      wb_stall,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      fwd_valid,
  output logic [REG_AW-1:0]         fwd_rd,
  output logic [DATA_W-1:0]         fwd_data,
  output logic [CNT_W-1:0]          retire_cnt
);

  if (NUM_SRC < 2 || SEL_W < clog2(NUM_SRC)) begin : g_bad_params
    $error("wb_stage_pipe: NUM_SRC must be >= 2 and SEL_W >= clog2(NUM_SRC)");
  end

  logic              valid_q;
  logic              regwrite_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  retire_cnt_q;
  logic [DATA_W-1:0] sel_data;
  logic              retire;
  logic              accept;
  logic              rd_suppressed;

  wb_src_mux #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_src_mux (
    .sel  (in_sel),
    .src  (in_src),
    .data (sel_data)
  );

  assign retire        = valid_q & ~wb_stall;
  assign in_ready      = ~valid_q | ~wb_stall;
  assign accept        = in_valid & in_ready & ~flush;
  assign rd_suppressed = ZERO_REG && (rd_q == '0);

  // Flush beats accept beats retire; a stalled entry simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too so rf_waddr/rf_wdata read 0 after reset.
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q    <= 1'b1;
        regwrite_q <= in_regwrite;
        rd_q       <= in_rd;
        data_q     <= sel_data;
      end else if (retire) begin
        valid_q <= 1'b0;
      end
      if (retire && !flush) retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign rf_we      = valid_q & regwrite_q & ~wb_stall & ~rd_suppressed;
  assign rf_waddr   = rd_q;
  assign rf_wdata   = data_q;
  assign fwd_valid  = valid_q & regwrite_q & ~rd_suppressed;
  assign fwd_rd     = rd_q;
  assign fwd_data   = data_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: a default instance plus a NUM_SRC=3/CNT_W=4
// instance sharing the same stimulus, checked by directed and random tests.
module tb_wb_stage_pipe;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_regwrite, flush, wb_stall;
  logic [2:0]  in_rd;
  logic [1:0]  in_sel;
  logic [31:0] in_src;

  logic        in_ready, rf_we, fwd_valid;
  logic [2:0]  rf_waddr, fwd_rd;
  logic [7:0]  rf_wdata, fwd_data;
  logic [15:0] retire_cnt;

  logic        s_in_ready, s_rf_we, s_fwd_valid;
  logic [2:0]  s_rf_waddr, s_fwd_rd;
  logic [7:0]  s_rf_wdata, s_fwd_data;
  logic [3:0]  s_retire_cnt;

  int compared = 0;
  int mismatched = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  wb_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_rd(in_rd), .in_sel(in_sel), .in_src(in_src),
    .flush(flush), .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .retire_cnt(retire_cnt)
  );

  wb_stage_pipe #(.NUM_SRC(3), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_regwrite(in_regwrite), .in_rd(in_rd), .in_sel(in_sel), .in_src(in_src[23:0]),
    .flush(flush), .wb_stall(wb_stall), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr),
    .rf_wdata(s_rf_wdata), .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd),
    .fwd_data(s_fwd_data), .retire_cnt(s_retire_cnt)
  );

  // Reference source pick: slice sel of the packed sources, zero if no such source.
  function automatic logic [7:0] pick(input logic [31:0] src, input logic [1:0] sel, input int n);
    if (int'(sel) >= n) return 8'h00;
    return src[int'(sel)*8 +: 8];
  endfunction

  task automatic drive(input logic v, input logic rw, input logic [2:0] rd,
                       input logic [1:0] sel, input logic fl, input logic st);
    in_valid = v; in_regwrite = rw; in_rd = rd; in_sel = sel; flush = fl; wb_stall = st;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    in_src = 32'h44332211;
    #12;
    rst_n = 1'b1;
    compared++;
    if (in_ready !== 1'b1 || rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: ready=%b we=%b fwd=%b want 1 0 0", in_ready, rf_we, fwd_valid);
    end
    compared++;
    if (rf_waddr !== 3'd0 || rf_wdata !== 8'h00 || retire_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_data: waddr=%0d wdata=%h cnt=%0d want 0", rf_waddr, rf_wdata, retire_cnt);
    end
    drive(1, 1, 3'd1, 2'(WB_SRC_SHIFT), 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 3'd2, 2'(WB_SRC_ALU), 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    compared++;
    if (rf_we !== 1'b1 || fwd_valid !== 1'b1 || retire_cnt !== 16'd1) begin
      mismatched++;
      $display("FAIL reset_pre: we=%b fwd=%b cnt=%0d want 1 1 1", rf_we, fwd_valid, retire_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || retire_cnt !== 16'd0 || s_retire_cnt !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_async: we=%b fwd=%b cnt=%0d scnt=%0d want 0", rf_we, fwd_valid, retire_cnt, s_retire_cnt);
    end
    #3;
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
    compared++;
    if (in_ready !== 1'b1 || rf_we !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: ready=%b we=%b want 1 0", in_ready, rf_we);
    end
  endtask

  task automatic test_select();
    in_src = 32'h44332211;
    drive(1, 1, 3'd5, 2'(WB_SRC_MEM), 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    compared++;
    if (rf_we !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== 8'h33) begin
      mismatched++;
      $display("FAIL select_write: we=%b waddr=%0d wdata=%h want 1 5 33", rf_we, rf_waddr, rf_wdata);
    end
    compared++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 3'd5 || fwd_data !== 8'h33 || s_rf_wdata !== 8'h33) begin
      mismatched++;
      $display("FAIL select_fwd: fwd=%b rd=%0d data=%h sdata=%h want 1 5 33 33", fwd_valid, fwd_rd, fwd_data, s_rf_wdata);
    end
    tick();
    exp_cnt += 1;
    compared++;
    if (retire_cnt !== 16'(exp_cnt) || rf_we !== 1'b0) begin
      mismatched++;
      $display("FAIL select_retire: cnt=%0d we=%b want %0d 0", retire_cnt, rf_we, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sels [3];
    logic [7:0] want [3];
    logic [7:0] swant [3];
    sels = '{2'(WB_SRC_SHIFT), 2'(WB_SRC_ALU), 2'(WB_SRC_IMM)};
    want = '{8'h11, 8'h22, 8'h44};
    swant = '{8'h11, 8'h22, 8'h00};
    in_src = 32'h44332211;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3'(i + 1), sels[i], 0, 0);
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
      end
      tick();
      compared++;
      if (rf_we !== 1'b1 || rf_waddr !== 3'(i + 1) || rf_wdata !== want[i] || s_rf_wdata !== swant[i]) begin
        mismatched++;
        $display("FAIL b2b_write%0d: we=%b waddr=%0d wdata=%h sdata=%h want 1 %0d %h %h",
                 i, rf_we, rf_waddr, rf_wdata, s_rf_wdata, i + 1, want[i], swant[i]);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    exp_cnt += 3;
    compared++;
    if (rf_we !== 1'b0 || retire_cnt !== 16'(exp_cnt)) begin
      mismatched++;
      $display("FAIL b2b_done: we=%b cnt=%0d want 0 %0d", rf_we, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall();
    in_src = 32'h44332211;
    drive(1, 1, 3'd4, 2'(WB_SRC_ALU), 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3'd6, 2'(WB_SRC_IMM), 0, 1);
      compared++;
      if (rf_we !== 1'b0 || in_ready !== 1'b0 || fwd_valid !== 1'b1 || fwd_data !== 8'h22 || fwd_rd !== 3'd4) begin
        mismatched++;
        $display("FAIL stall_hold%0d: we=%b ready=%b fwd=%b data=%h rd=%0d want 0 0 1 22 4",
                 i, rf_we, in_ready, fwd_valid, fwd_data, fwd_rd);
      end
      tick();
    end
    compared++;
    if (retire_cnt !== 16'(exp_cnt)) begin
      mismatched++;
      $display("FAIL stall_cnt: got %0d want %0d", retire_cnt, exp_cnt);
    end
    drive(1, 1, 3'd6, 2'(WB_SRC_IMM), 0, 0);
    compared++;
    if (rf_we !== 1'b1 || in_ready !== 1'b1 || rf_wdata !== 8'h22) begin
      mismatched++;
      $display("FAIL stall_release: we=%b ready=%b wdata=%h want 1 1 22", rf_we, in_ready, rf_wdata);
    end
    tick();
    exp_cnt += 1;
    drive(0, 0, 0, 0, 0, 0);
    compared++;
    if (rf_we !== 1'b1 || rf_waddr !== 3'd6 || rf_wdata !== 8'h44 || retire_cnt !== 16'(exp_cnt)) begin
      mismatched++;
      $display("FAIL stall_next: we=%b waddr=%0d wdata=%h cnt=%0d want 1 6 44 %0d",
               rf_we, rf_waddr, rf_wdata, retire_cnt, exp_cnt);
    end
    tick();
    exp_cnt += 1;
  endtask

  task automatic test_flush_zero();
    in_src = 32'h44332211;
    drive(1, 1, 3'd7, 2'(WB_SRC_SHIFT), 0, 0);
    tick();
    drive(1, 1, 3'd3, 2'(WB_SRC_ALU), 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    compared++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || in_ready !== 1'b1 || retire_cnt !== 16'(exp_cnt)) begin
      mismatched++;
      $display("FAIL flush: we=%b fwd=%b ready=%b cnt=%0d want 0 0 1 %0d",
               rf_we, fwd_valid, in_ready, retire_cnt, exp_cnt);
    end
    drive(1, 1, 3'd0, 2'(WB_SRC_IMM), 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    compared++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_reg: we=%b fwd=%b ready=%b want 0 0 1", rf_we, fwd_valid, in_ready);
    end
    tick();
    exp_cnt += 1;
    compared++;
    if (retire_cnt !== 16'(exp_cnt)) begin
      mismatched++;
      $display("FAIL zero_reg_cnt: got %0d want %0d", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    drive(1, 0, 3'd2, 2'(WB_SRC_ALU), 0, 0);
    tick();
    repeat (15) tick();
    compared++;
    if (s_retire_cnt !== 4'd15 || retire_cnt !== 16'd15) begin
      mismatched++;
      $display("FAIL wrap_15: scnt=%0d cnt=%0d want 15 15", s_retire_cnt, retire_cnt);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    compared++;
    if (s_retire_cnt !== 4'd0 || retire_cnt !== 16'd16) begin
      mismatched++;
      $display("FAIL wrap_16: scnt=%0d cnt=%0d want 0 16", s_retire_cnt, retire_cnt);
    end
  endtask

  typedef struct {
    bit         rw;
    logic [2:0] rd;
    logic [7:0] d;
    logic [7:0] ds;
  } entry_t;

  task automatic test_random();
    entry_t held [$];
    entry_t last;
    entry_t nxt;
    int     cnt;
    bit     v, ready, ret, acc, we, fv, zero;
    pulse_reset();
    last = '{0, 3'd0, 8'h00, 8'h00};
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      in_src = $urandom;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), 2'($urandom),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0));
      v     = held.size() != 0;
      zero  = (last.rd == 3'd0);
      ready = !v || !wb_stall;
      we    = v && last.rw && !wb_stall && !zero;
      fv    = v && last.rw && !zero;
      compared++;
      if (in_ready !== ready || rf_we !== we || fwd_valid !== fv || s_rf_we !== we) begin
        mismatched++;
        $display("FAIL rand_ctrl c%0d: ready=%b we=%b fwd=%b swe=%b want %b %b %b %b",
                 c, in_ready, rf_we, fwd_valid, s_rf_we, ready, we, fv, we);
      end
      compared++;
      if (rf_waddr !== last.rd || rf_wdata !== last.d || fwd_data !== last.d || s_rf_wdata !== last.ds) begin
        mismatched++;
        $display("FAIL rand_data c%0d: waddr=%0d wdata=%h fwd=%h sdata=%h want %0d %h %h %h",
                 c, rf_waddr, rf_wdata, fwd_data, s_rf_wdata, last.rd, last.d, last.d, last.ds);
      end
      compared++;
      if (retire_cnt !== 16'(cnt) || s_retire_cnt !== 4'(cnt % 16)) begin
        mismatched++;
        $display("FAIL rand_cnt c%0d: cnt=%0d scnt=%0d want %0d %0d",
                 c, retire_cnt, s_retire_cnt, cnt, cnt % 16);
      end
      ret = v && !wb_stall;
      acc = in_valid && ready && !flush;
      if (flush) begin
        held.delete();
      end else if (acc) begin
        nxt = '{in_regwrite, in_rd, pick(in_src, in_sel, 4), pick(in_src, in_sel, 3)};
        held.delete();
        held.push_back(nxt);
        last = nxt;
      end else if (ret) begin
        held.delete();
      end
      if (ret && !flush) cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_back_to_back();
    test_stall();
    test_flush_zero();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
